// File: rtl/sr_drive_pkg.sv
// Shared types and defaults for the sr_latch drive controller.
package sr_drive_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PULSE_S,
    PULSE_R,
    GAP
  } state_e;

  localparam logic DIR_SET = 1'b0;
  localparam logic DIR_RST = 1'b1;

  localparam int DEF_DEB_CYCLES   = 4;
  localparam int DEF_PULSE_CYCLES = 2;
  localparam int DEF_GAP_CYCLES   = 1;

endpackage

// File: rtl/sr_drive_ctrl_if.sv
// Request inputs and latch drive outputs of sr_drive_ctrl.
interface sr_drive_ctrl_if;
  import sr_drive_pkg::*;

  logic set_req;
  logic rst_req;
  logic S;
  logic R;
  logic busy;
  logic q_exp;
  logic conflict;

  modport master (
    input  set_req, rst_req,
    output S, R, busy, q_exp, conflict
  );

  modport slave (
    output set_req, rst_req,
    input  S, R, busy, q_exp, conflict
  );

endinterface

// File: rtl/sr_drive_ctrl_debounce.sv
// 2-flop synchronizer plus debounce counter; one-cycle event on
// each debounced rising transition.
module sr_debounce
  import sr_drive_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] DEB_TOP = CW'(DEB_CYCLES);

  logic          s1_q, s2_q;
  logic          lvl_q, lvl_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    lvl_d  = lvl_q;
    rise_d = 1'b0;
    if (cnt_q == DEB_TOP) begin
      lvl_d  = ~lvl_q;
      rise_d = ~lvl_q;
      cnt_d  = '0;
    end else if (s2_q != lvl_q) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= din;
      s2_q   <= s1_q;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      cnt_q  <= cnt_d;
    end
  end

  assign level = lvl_q;
  assign rise  = rise_q;

endmodule

// File: rtl/sr_drive_ctrl.sv
// Debounced, arbitrated S/R pulse generator for sr_latch.
// Optional SR_SKIP_REDUNDANT_EN drops events matching q_exp.
module sr_drive_ctrl
  import sr_drive_pkg::*;
#(
  parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES
) (
  input logic              clk,
  input logic              rst_n,
  sr_drive_ctrl_if.master  bus
);

  localparam int MAXC = (PULSE_CYCLES > GAP_CYCLES) ?
                        PULSE_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] P_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] G_LAST = CW'(GAP_CYCLES - 1);

  logic set_lvl, set_rise;
  logic rst_lvl, rst_rise;
  logic unused_lvl;

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_set (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.set_req),
    .level (set_lvl),
    .rise  (set_rise)
  );

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_rst (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.rst_req),
    .level (rst_lvl),
    .rise  (rst_rise)
  );

  assign unused_lvl = set_lvl ^ rst_lvl;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          q_q, q_d;
  logic          pv_q, pv_d;
  logic          pd_q, pd_d;
  logic          cf_q, cf_d;
  logic          ev_raw, ev_dir, ev_v, take_dir;

  // Reset wins before any redundancy filtering.
  assign ev_raw = set_rise | rst_rise;
  assign ev_dir = rst_rise ? DIR_RST : DIR_SET;
`ifdef SR_SKIP_REDUNDANT_EN
  assign ev_v = ev_raw & ((ev_dir == DIR_SET) ? ~q_q : q_q);
`else
  assign ev_v = ev_raw;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    q_d      = q_q;
    pv_d     = pv_q;
    pd_d     = pd_q;
    cf_d     = set_rise & rst_rise;
    take_dir = ev_v ? ev_dir : pd_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        pv_d  = 1'b0;
        if (ev_v || pv_q)
          state_d = (take_dir == DIR_RST) ? PULSE_R : PULSE_S;
      end
      PULSE_S, PULSE_R: begin
        if (cnt_q == P_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
          q_d     = (state_q == PULSE_S);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == G_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && ev_v) begin
      pv_d = 1'b1;
      pd_d = ev_dir;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      pv_q    <= 1'b0;
      pd_q    <= DIR_SET;
      cf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      pv_q    <= pv_d;
      pd_q    <= pd_d;
      cf_q    <= cf_d;
    end
  end

  assign bus.S        = (state_q == PULSE_S);
  assign bus.R        = (state_q == PULSE_R);
  assign bus.busy     = (state_q != IDLE);
  assign bus.q_exp    = q_q;
  assign bus.conflict = cf_q;

endmodule
